// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Start/done handshake; bcd_out and overflow hold their value between conversions.
// Optional macro BIN_TO_BCD_SATURATE_EN: an overflowing result loads all-9s into
// bcd_out instead of the truncated (mod 10^DIGITS) value.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_WIDTH = 10,
    parameter int unsigned DIGITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = 6;
    localparam logic [CntW-1:0] LastCnt = CntW'(BIN_WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic [BIN_WIDTH-1:0]  shift_q, shift_d;
    logic [BcdW-1:0]       scratch_q, scratch_d;
    logic                  ovf_scr_q, ovf_scr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [BcdW-1:0]       bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;

    logic [BcdW-1:0]       corr;
    logic [BcdW-1:0]       scr_shifted;
    logic [BIN_WIDTH-1:0]  shift_next;
    logic                  ovf_next;
    logic [BcdW-1:0]       result;

    // Per-digit add-3 correction followed by the one-bit shift of {scratch, shiftreg}.
    always_comb begin
        corr = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            logic [3:0] dig;
            dig = scratch_q[4*k +: 4];
            corr[4*k +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
        end
        scr_shifted = {corr[BcdW-2:0], shift_q[BIN_WIDTH-1]};
        shift_next  = shift_q << 1;
        // A bit leaving the top digit means the prefix value has reached 10^DIGITS.
        ovf_next    = ovf_scr_q | corr[BcdW-1];
`ifdef BIN_TO_BCD_SATURATE_EN
        result      = ovf_next ? {DIGITS{4'h9}} : scr_shifted;
`else
        result      = scr_shifted;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        ovf_scr_d = ovf_scr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    ovf_scr_d = 1'b0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shift_d   = shift_next;
                scratch_d = scr_shifted;
                ovf_scr_d = ovf_next;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    bcd_d   = result;
                    ovf_d   = ovf_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            ovf_scr_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            ovf_scr_q <= ovf_scr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 10-bit/4-digit instance and a
// 10-bit/3-digit instance for the overflow cases.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start, start3;
    logic [9:0]  bin_in, bin3;
    logic        busy, done, overflow;
    logic [15:0] bcd_out;
    logic        busy3, done3, overflow3;
    logic [11:0] bcd3;

    exp_t q4[$];
    exp_t q3[$];
    int   total;
    int   bad;
    int   ndone4;
    int   ndone3;

    bin_to_bcd_seq #(.BIN_WIDTH(10), .DIGITS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    bin_to_bcd_seq #(.BIN_WIDTH(10), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .bin_in(bin3),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(overflow3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the head of the matching queue.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            ndone4++;
            if (q4.size() == 0) begin
                check("unexpected_done4", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                check("bcd4", 32'(bcd_out), 32'(e.bcd));
                check("ovf4", 32'(overflow), 32'(e.ovf));
            end
        end
        if (done3 === 1'b1) begin
            exp_t e;
            ndone3++;
            if (q3.size() == 0) begin
                check("unexpected_done3", 32'd1, 32'd0);
            end else begin
                e = q3.pop_front();
                check("bcd3", 32'(bcd3), 32'(e.bcd[11:0]));
                check("ovf3", 32'(overflow3), 32'(e.ovf));
            end
        end
    end

    // Present one start pulse to the 4-digit DUT; returns just after the accepting edge.
    task automatic issue4(input logic [9:0] v, input logic [15:0] eb, input logic eo);
        start  = 1'b1;
        bin_in = v;
        q4.push_back('{bcd: eb, ovf: eo});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic issue3(input logic [9:0] v, input logic [11:0] eb, input logic eo);
        start3 = 1'b1;
        bin3   = v;
        q3.push_back('{bcd: {4'h0, eb}, ovf: eo});
        @(posedge clk);
        #1 start3 = 1'b0;
    endtask

    // Bounded wait for done on the 4-digit DUT; reports latency and busy cycles.
    task automatic wait_done4(output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (busy) bsy++;
            if (done) break;
            if (lat > 40) begin
                check("timeout4", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic wait_done3();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (done3) break;
            if (n > 40) begin
                check("timeout3", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    initial begin
        int lat, bsy;
        exp_t sat;
        total = 0; bad = 0; ndone4 = 0; ndone3 = 0;
        start = 1'b0; start3 = 1'b0; bin_in = '0; bin3 = '0;
        rst_n = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero: latency 11 edges, busy for 10 cycles.
        issue4(10'd0, 16'h0000, 1'b0);
        wait_done4(lat, bsy);
        check("lat_zero", 32'(lat), 32'd11);
        check("busy_cycles", 32'(bsy), 32'd10);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        issue4(10'd1023, 16'h1023, 1'b0);
        wait_done4(lat, bsy);
        issue4(10'd999, 16'h0999, 1'b0);
        wait_done4(lat, bsy);
        issue4(10'd100, 16'h0100, 1'b0);
        wait_done4(lat, bsy);

        // Three-digit instance: overflow and saturation behaviour.
`ifdef BIN_TO_BCD_SATURATE_EN
        sat.bcd = 16'h0999;
`else
        sat.bcd = 16'h0000;
`endif
        issue3(10'd1000, sat.bcd[11:0], 1'b1);
        wait_done3();
        issue3(10'd999, 12'h999, 1'b0);
        wait_done3();
`ifdef BIN_TO_BCD_SATURATE_EN
        sat.bcd = 16'h0999;
`else
        sat.bcd = 16'h0023;
`endif
        issue3(10'd1023, sat.bcd[11:0], 1'b1);
        wait_done3();

        // Start while busy is ignored.
        issue4(10'd5, 16'h0005, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; bin_in = 10'd7;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        wait_done4(lat, bsy);
        check("lat_busy_start", 32'(lat), 32'd6);
        repeat (15) @(negedge clk);
        check("no_extra_done", 32'(ndone4), 32'd5);

        // Held start: back-to-back conversions 11 cycles apart.
        @(posedge clk); #1;
        start = 1'b1; bin_in = 10'd42;
        q4.push_back('{bcd: 16'h0042, ovf: 1'b0});
        @(posedge clk); #1;
        bin_in = 10'd43;
        q4.push_back('{bcd: 16'h0043, ovf: 1'b0});
        wait_done4(lat, bsy);
        check("held_lat1", 32'(lat), 32'd11);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done4(lat, bsy);
        check("held_lat2", 32'(lat), 32'd11);

        // Asynchronous reset mid-conversion.
        issue4(10'd512, 16'h0512, 1'b0);
        wait_done4(lat, bsy);
        check("bcd_512_hold", 32'(bcd_out), 32'h0512);
        start = 1'b1; bin_in = 10'd77;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_bcd", 32'(bcd_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("after_arst_done_count", 32'(ndone4), 32'd8);
        check("q4_empty", 32'(q4.size()), 32'd0);
        check("q3_empty", 32'(q3.size()), 32'd0);
        check("done3_count", 32'(ndone3), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble converter: turns an unsigned binary value into packed BCD digits, one bit per clock.
- Sits directly upstream of the per-digit seven-segment decoders. Each 4-bit field of bcd_out drives one decoder's hex input, so counters and ALU results show as decimal on the board displays.
- Start/done handshake; the result is held stable between conversions.

Parameters:
- BIN_WIDTH, 10, width of binary input; legal 1..32.
- DIGITS, 4, number of BCD output digits; legal 1..10.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of bin_in; sampled only in IDLE.
- bin_in  input  BIN_WIDTH  unsigned value; captured on the accepting edge, ignored otherwise.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: bcd_out and overflow just updated.
- bcd_out  output  4*DIGITS  packed BCD; digit k at bits [4k+3:4k], digit 0 = units.
- overflow  output  1  last result exceeded 10^DIGITS-1; updated with done.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, and internal shift/scratch/counter registers cleared. Deassertion needs no special sequencing; the first start is accepted on the first edge after release.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge N:
  - load bin_in into the shift register;
  - clear the BCD scratch and the sticky overflow scratch;
  - counter=0, go to SHIFT.
  - busy is registered and goes high after edge N.
- IDLE, start=0: hold; bcd_out and overflow are unchanged.
- SHIFT, each edge, in this order:
  1. every scratch digit >=5 gets +3 (4-bit add, no carry between digits);
  2. shift {scratch, shiftreg} left by 1, MSB of shiftreg entering digit 0 bit 0;
  3. the bit shifted out of the top digit is ORed into the overflow scratch;
  4. counter+1.
- Last shift (counter==BIN_WIDTH-1), same edge:
  - bcd_out <= post-shift scratch;
  - overflow <= post-shift overflow scratch;
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at edge N gives done high during the cycle after edge N+BIN_WIDTH, and busy high for exactly BIN_WIDTH cycles.
- done is high for exactly one cycle and cleared on the next edge.
- start while busy: ignored, no queuing, current conversion unaffected.
- start high in the done cycle: accepted (state is IDLE), so held start gives one conversion every BIN_WIDTH+1 cycles.
- Width rule: without the optional feature, the result is value mod 10^DIGITS; overflow=1 iff value > 10^DIGITS-1.
- bin_in changing mid-conversion has no effect.
- Reset mid-conversion aborts immediately:
  - no done pulse;
  - bcd_out and overflow go to 0, not the prior result.

Optional Feature:
- Macro: BIN_TO_BCD_SATURATE_EN.
- Defined: on a conversion with overflow=1, bcd_out is loaded with all digits 4'h9 instead of the truncated value. overflow and done timing are unchanged.
- Undefined: truncated (mod 10^DIGITS) result as above.

Test Plan:
- Defaults; reset, then start=1 for one cycle with bin_in=0 -> done after 11 edges, bcd_out=16'h0000, overflow=0, busy high exactly 10 cycles.
- Defaults; bin_in=1023 -> bcd_out=16'h1023, overflow=0. bin_in=999 -> bcd_out=16'h0999.
- BIN_WIDTH=10, DIGITS=3; bin_in=1000 -> overflow=1; bcd_out=12'h000 with macro undefined, 12'h999 with it defined. bin_in=999 -> 12'h999, overflow=0.
- Defaults; start pulse with bin_in=5, then start=1 with bin_in=7 on edges 3-6 -> exactly one done, bcd_out=16'h0005.
- Defaults; start held high, bin_in stepping 42, 43 each accepted cycle -> done pulses 11 cycles apart, results 16'h0042 then 16'h0043.
- Defaults; complete bin_in=512 (bcd_out=16'h0512), start bin_in=77, pull rst_n low mid-SHIFT (async, between edges) -> bcd_out=0, busy=0, done=0 immediately, no done pulse follows.
